// File: rtl/flash_model_ctl_pkg.sv
// Shared types and constants for the StrataFlash-style command model:
// mode enum, command opcodes, status bit positions and a status-byte helper.
package flash_pkg;

  typedef enum logic [2:0] {
    MODE_READ_ARRAY,
    MODE_READ_STATUS,
    MODE_PROG_SETUP,
    MODE_ERASE_SETUP,
    MODE_BUSY_PROG,
    MODE_BUSY_ERASE
  } mode_e;

  localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
  localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
  localparam logic [7:0] CMD_PROGRAM      = 8'h40;
  localparam logic [7:0] CMD_PROGRAM_ALT  = 8'h10;
  localparam logic [7:0] CMD_ERASE        = 8'h20;
  localparam logic [7:0] CMD_CONFIRM      = 8'hD0;

  localparam int ST_READY     = 7;
  localparam int ST_ERASE_ERR = 5;
  localparam int ST_PROG_ERR  = 4;
  localparam int ST_PROT_ERR  = 1;

  typedef struct packed {
    logic erase_err;
    logic prog_err;
    logic prot_err;
  } err_t;

  function automatic logic [7:0] status_byte(input logic ready, input err_t e);
    logic [7:0] s;
    s               = '0;
    s[ST_READY]     = ready;
    s[ST_ERASE_ERR] = e.erase_err;
    s[ST_PROG_ERR]  = e.prog_err;
    s[ST_PROT_ERR]  = e.prot_err;
    return s;
  endfunction

endpackage

// File: rtl/flash_model_ctl_if.sv
// NF_* control bus between the flash controller (master) and the model (slave).
// The bidirectional data bus stays a plain inout port on the model.
interface flash_model_ctl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] NF_A;
  logic              NF_CE;
  logic              NF_OE;
  logic              NF_WE;
  logic              NF_RP;
  logic              NF_WP;
  logic              NF_STS;

  modport master (output NF_A, NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, input NF_STS);
  modport slave  (input NF_A, NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, output NF_STS);
endinterface

// File: rtl/flash_model_ctl_we_capture.sv
// Bus-write capture: registers NF_A/NF_D every clock the chip is selected with
// WE low, and emits a registered one-clock wr_stb once WE is seen high again.
module flash_we_capture #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] a_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [ADDR_W-1:0] a_o,
  output logic [DATA_W-1:0] d_o,
  output logic              wr_stb_o
);

  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              armed_q, armed_d;
  logic              stb_q, stb_d;

  always_comb begin
    a_d     = a_q;
    d_d     = d_q;
    armed_d = armed_q;
    stb_d   = 1'b0;
    if (!ce_n && !we_n) begin
      a_d     = a_i;
      d_d     = d_i;
      armed_d = 1'b1;
    end else if (armed_q && we_n) begin
      // first high sample of WE after a captured low one closes the write
      stb_d   = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      d_q     <= '0;
      armed_q <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      d_q     <= d_d;
      armed_q <= armed_d;
      stb_q   <= stb_d;
    end
  end

  assign a_o      = a_q;
  assign d_o      = d_q;
  assign wr_stb_o = stb_q;

endmodule

// File: rtl/flash_model_ctl.sv
// Clocked NOR flash model: read-array/status, program, block erase, busy on NF_STS.
// Optional block-0 write protection via NF_WP when FLASH_MODEL_WP_EN is defined.
module flash_model_ctl
  import flash_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int BLK_W        = 4,
  parameter int PROG_CYCLES  = 16,
  parameter int ERASE_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_model_ctl_if.slave     bus,
  inout  wire  [DATA_W-1:0]    NF_D
);

  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

  // NF_RP low behaves exactly like the synchronous reset
  logic rst_i;
  assign rst_i = rst | ~bus.NF_RP;

  logic [ADDR_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_d;
  logic              wr_stb;

  flash_we_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap (
    .clk      (clk),
    .rst      (rst_i),
    .ce_n     (bus.NF_CE),
    .we_n     (bus.NF_WE),
    .a_i      (bus.NF_A),
    .d_i      (NF_D),
    .a_o      (cap_a),
    .d_o      (cap_d),
    .wr_stb_o (wr_stb)
  );

  // Array powers up erased; deliberately untouched by any reset
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1] = '{default: '1};

  mode_e             mode_q, mode_d;
  err_t              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_d_q, op_d_d;
  logic              prog_apply, erase_apply;
  logic              wp_hit;

`ifdef FLASH_MODEL_WP_EN
  assign wp_hit = !bus.NF_WP && (cap_a[ADDR_W-1:BLK_W] == '0);
`else
  logic unused_wp;
  assign unused_wp = bus.NF_WP;
  assign wp_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      mode_q <= MODE_READ_ARRAY;
      err_q  <= '0;
      cnt_q  <= '0;
      op_a_q <= '0;
      op_d_q <= '0;
    end else begin
      mode_q <= mode_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      op_a_q <= op_a_d;
      op_d_q <= op_d_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d      = mode_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_d_d      = op_d_q;
    prog_apply  = 1'b0;
    erase_apply = 1'b0;
    case (mode_q)
      MODE_READ_ARRAY, MODE_READ_STATUS: begin
        if (wr_stb) begin
          case (cap_d[7:0])
            CMD_READ_ARRAY:   mode_d = MODE_READ_ARRAY;
            CMD_READ_STATUS:  mode_d = MODE_READ_STATUS;
            CMD_CLEAR_STATUS: err_d  = '0;
            CMD_PROGRAM,
            CMD_PROGRAM_ALT:  mode_d = MODE_PROG_SETUP;
            CMD_ERASE:        mode_d = MODE_ERASE_SETUP;
            default:          mode_d = mode_q;
          endcase
        end
      end
      MODE_PROG_SETUP: begin
        if (wr_stb) begin
          if (wp_hit) begin
            err_d.prot_err = 1'b1;
            err_d.prog_err = 1'b1;
            mode_d         = MODE_READ_STATUS;
          end else begin
            op_a_d = cap_a;
            op_d_d = cap_d;
            cnt_d  = PROG_LOAD;
            mode_d = MODE_BUSY_PROG;
          end
        end
      end
      MODE_ERASE_SETUP: begin
        if (wr_stb) begin
          if (cap_d[7:0] != CMD_CONFIRM) begin
            err_d.erase_err = 1'b1;
            err_d.prog_err  = 1'b1;
            mode_d          = MODE_READ_STATUS;
          end else if (wp_hit) begin
            err_d.prot_err  = 1'b1;
            err_d.erase_err = 1'b1;
            mode_d          = MODE_READ_STATUS;
          end else begin
            op_a_d = cap_a;
            cnt_d  = ERASE_LOAD;
            mode_d = MODE_BUSY_ERASE;
          end
        end
      end
      MODE_BUSY_PROG: begin
        if (cnt_q == '0) begin
          prog_apply = 1'b1;
          mode_d     = MODE_READ_STATUS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MODE_BUSY_ERASE: begin
        if (cnt_q == '0) begin
          erase_apply = 1'b1;
          mode_d      = MODE_READ_STATUS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: mode_d = MODE_READ_ARRAY;
    endcase
  end

  // Array update lands on the same edge the FSM leaves busy, so NF_STS
  // and the new contents become visible together. Reset aborts it.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      if (prog_apply)
        mem[op_a_q] <= mem[op_a_q] & op_d_q;
      if (erase_apply)
        for (int j = 0; j < (1 << BLK_W); j++)
          mem[{op_a_q[ADDR_W-1:BLK_W], BLK_W'(j)}] <= '1;
    end
  end

  // Outputs
  logic              busy;
  logic [7:0]        status_w;
  logic [DATA_W-1:0] rd_data;
  logic              drive;

  always_comb begin
    busy     = (mode_q == MODE_BUSY_PROG) || (mode_q == MODE_BUSY_ERASE);
    status_w = status_byte(~busy, err_q);
    rd_data  = '0;
    if (mode_q == MODE_READ_ARRAY)
      rd_data = mem[bus.NF_A];
    else
      rd_data[7:0] = status_w;
    drive    = !bus.NF_CE && !bus.NF_OE && bus.NF_WE && bus.NF_RP;
  end

  assign bus.NF_STS = ~busy;
  assign NF_D       = drive ? rd_data : 'z;

endmodule

// File: tb/tb_flash_model_ctl.sv
// Scoreboarded bench for flash_model_ctl: stimulus queues expected reads and
// busy lengths; a negedge monitor pops and compares them.
module tb_flash_model_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_model_ctl_if #(.ADDR_W(8)) bus ();

  wire  [7:0] nf_d;
  logic       tb_den  = 1'b0;
  logic [7:0] tb_dout = 8'h00;
  assign nf_d = tb_den ? tb_dout : 8'hzz;

  flash_model_ctl #(
    .ADDR_W(8), .DATA_W(8), .BLK_W(4), .PROG_CYCLES(16), .ERASE_CYCLES(256)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .NF_D (nf_d)
  );

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       sts;
  } rd_exp_t;

  typedef struct {
    string name;
    int    len;
  } busy_exp_t;

  rd_exp_t   rd_q[$];
  busy_exp_t busy_q[$];
  int        total = 0;
  int        bad   = 0;
  int        busy_run = 0;
  logic      rd_vld = 1'b0;

  // Monitor
  always @(negedge clk) begin
    rd_exp_t   e;
    busy_exp_t b;
    if (rd_vld) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got d=%h", nf_d);
      end else begin
        e = rd_q.pop_front();
        if (nf_d !== e.d || bus.NF_STS !== e.sts) begin
          bad++;
          $display("FAIL %s: got d=%h sts=%b, want d=%h sts=%b", e.name, nf_d, bus.NF_STS, e.d, e.sts);
        end
      end
    end
    if (!rst) begin
      if (bus.NF_STS === 1'b0) busy_run++;
      else if (busy_run > 0) begin
        total++;
        if (busy_q.size() == 0) begin
          bad++;
          $display("FAIL busy_unexpected: got len=%0d, want none", busy_run);
        end else begin
          b = busy_q.pop_front();
          if (busy_run != b.len) begin
            bad++;
            $display("FAIL %s: got len=%0d, want len=%0d", b.name, busy_run, b.len);
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.NF_A  = a;
    tb_dout   = d;
    tb_den    = 1'b1;
    bus.NF_CE = 1'b0;
    bus.NF_WE = 1'b0;
    cyc();
    bus.NF_WE = 1'b1;
    bus.NF_CE = 1'b1;
    tb_den    = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic sts, input string name);
    rd_exp_t e;
    e.name = name; e.d = d; e.sts = sts;
    rd_q.push_back(e);
    bus.NF_A  = a;
    bus.NF_CE = 1'b0;
    bus.NF_OE = 1'b0;
    rd_vld    = 1'b1;
    cyc();
    rd_vld    = 1'b0;
    bus.NF_CE = 1'b1;
    bus.NF_OE = 1'b1;
  endtask

  task automatic expect_busy(input string name, input int len);
    busy_exp_t b;
    b.name = name; b.len = len;
    busy_q.push_back(b);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.NF_STS !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.NF_STS !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got sts=%b after %0d clocks, want 1", name, bus.NF_STS, n);
    end
    cyc();
  endtask

  initial begin
    bus.NF_A  = '0;
    bus.NF_CE = 1'b1;
    bus.NF_OE = 1'b1;
    bus.NF_WE = 1'b1;
    bus.NF_RP = 1'b1;
    bus.NF_WP = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    rd(8'h12, 8'hFF, 1'b1, "reset_read_array");
    wr(8'h00, 8'h70);
    rd(8'h00, 8'h80, 1'b1, "reset_status");

    // Program 0xA5 at 0x12
    wr(8'h12, 8'h40);
    expect_busy("prog_busy_a5", 16);
    wr(8'h12, 8'hA5);
    rd(8'h12, 8'h00, 1'b0, "status_while_busy");
    wait_ready("prog_a5");
    rd(8'h12, 8'h80, 1'b1, "status_after_prog");
    wr(8'h00, 8'hFF);
    rd(8'h12, 8'hA5, 1'b1, "read_a5");

    // Program 0x5A over 0xA5 -> AND result, using the alternate opcode
    wr(8'h12, 8'h10);
    expect_busy("prog_busy_5a", 16);
    wr(8'h12, 8'h5A);
    wait_ready("prog_5a");
    wr(8'h00, 8'hFF);
    rd(8'h12, 8'h00, 1'b1, "read_and_result");

    // Words just outside and at the far edge of the erase block
    wr(8'h20, 8'h40);
    expect_busy("prog_busy_20", 16);
    wr(8'h20, 8'h77);
    wait_ready("prog_20");
    wr(8'h1F, 8'h40);
    expect_busy("prog_busy_1f", 16);
    wr(8'h1F, 8'h11);
    wait_ready("prog_1f");

    // Block erase via 0x13 clears 0x10..0x1F only
    wr(8'h13, 8'h20);
    expect_busy("erase_busy", 256);
    wr(8'h13, 8'hD0);
    wait_ready("erase");
    wr(8'h00, 8'hFF);
    rd(8'h10, 8'hFF, 1'b1, "erase_lo");
    rd(8'h12, 8'hFF, 1'b1, "erase_mid");
    rd(8'h1F, 8'hFF, 1'b1, "erase_hi");
    rd(8'h20, 8'h77, 1'b1, "erase_neighbour");

    // Bad erase confirm, then clear status
    wr(8'h00, 8'h20);
    wr(8'h00, 8'h33);
    rd(8'h00, 8'hB0, 1'b1, "seq_error_status");
    wr(8'h00, 8'h50);
    rd(8'h00, 8'h80, 1'b1, "cleared_status");

    // Abort a program with NF_RP after 5 busy clocks
    wr(8'h30, 8'h40);
    expect_busy("abort_busy", 5);
    wr(8'h30, 8'h00);
    repeat (5) @(negedge clk);
    bus.NF_RP = 1'b0;
    @(posedge clk); #1;
    bus.NF_RP = 1'b1;
    cyc();
    rd(8'h30, 8'hFF, 1'b1, "abort_word_mode");
    wr(8'h00, 8'h70);
    rd(8'h00, 8'h80, 1'b1, "abort_status");

    // rst coinciding with the WE rising sample drops the write
    bus.NF_A  = 8'h00;
    tb_dout   = 8'h70;
    tb_den    = 1'b1;
    bus.NF_CE = 1'b0;
    bus.NF_WE = 1'b0;
    cyc();
    bus.NF_WE = 1'b1;
    bus.NF_CE = 1'b1;
    tb_den    = 1'b0;
    rst       = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    rd(8'h30, 8'hFF, 1'b1, "rst_drops_write");

    // Write protect on block 0
    bus.NF_WP = 1'b0;
    wr(8'h03, 8'h40);
`ifdef FLASH_MODEL_WP_EN
    wr(8'h03, 8'h3C);
    rd(8'h03, 8'h92, 1'b1, "wp_status");
    wr(8'h00, 8'h50);
    wr(8'h00, 8'hFF);
    rd(8'h03, 8'hFF, 1'b1, "wp_word_unchanged");
`else
    expect_busy("wp_ignored_busy", 16);
    wr(8'h03, 8'h3C);
    wait_ready("wp_ignored");
    rd(8'h03, 8'h80, 1'b1, "wp_ignored_status");
    wr(8'h00, 8'hFF);
    rd(8'h03, 8'h3C, 1'b1, "wp_ignored_word");
`endif
    bus.NF_WP = 1'b1;
    cyc();

    total++;
    if (rd_q.size() != 0 || busy_q.size() != 0 || busy_run != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got rd=%0d busy=%0d run=%0d, want all 0",
               rd_q.size(), busy_q.size(), busy_run);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_model_ctl.md
# flash_model_ctl

Clocked, parametrised successor to the board's parallel NOR flash simulation model. It models an Intel-StrataFlash-style command interface: read-array, read-status, program and block-erase, with busy timing on `NF_STS` and NOR bit-clearing semantics. The block sits in the testbench tree opposite the flash controller, on the `NF_*` bus. It is written in the synthesisable subset so that it can also run inside the FPGA as a flash stand-in.

## Interface
- `ADDR_W`, 8: address width; the array holds 2**ADDR_W words.
- `DATA_W`, 8: data width, ≥ 8; status occupies bits [7:0], upper bits read 0.
- `BLK_W`, 4: log2 words per erase block.
- `PROG_CYCLES`, 16: clocks a program operation stays busy, ≥ 1.
- `ERASE_CYCLES`, 256: clocks an erase operation stays busy, ≥ 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `NF_A` in ADDR_W: word address.
- `NF_D` inout DATA_W: data bus; driven only during reads.
- `NF_CE` in 1: chip enable, active low.
- `NF_OE` in 1: output enable, active low.
- `NF_WE` in 1: write enable, active low.
- `NF_RP` in 1: reset/power-down, active low.
- `NF_WP` in 1: write protect, active low.
- `NF_STS` out 1: 1 = ready, 0 = busy.

## Operation
- Array contents initialise to all ones at time 0. Neither `rst` nor `NF_RP` clears the array.
- Bus write capture:
  - While `NF_CE`=0 and `NF_WE`=0, `NF_A` and `NF_D` are registered every clock.
  - A bus write completes on the first clock where `NF_WE` samples 1 after sampling 0.
  - That write uses the last captured address and data.
- Read path:
  - `NF_D` is driven when `NF_CE`=0, `NF_OE`=0, `NF_WE`=1 and `NF_RP`=1; otherwise it is Z.
  - In READ_ARRAY the bus shows `mem[NF_A]`; in every other mode it shows the status register.
- Status register:
  - bit7 = ready.
  - bit5 = erase/sequence error.
  - bit4 = program/sequence error.
  - bit1 = block-protected error.
  - All other bits read 0.
- Mode FSM states: READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE.
- Command decode in READ_ARRAY / READ_STATUS (data[7:0]):
  - 0xFF → READ_ARRAY.
  - 0x70 → READ_STATUS.
  - 0x50 → clear bits 5, 4 and 1; mode unchanged.
  - 0x40 or 0x10 → PROG_SETUP.
  - 0x20 → ERASE_SETUP.
  - Any other value → ignored.
- PROG_SETUP:
  - The next write latches address and data.
  - `mem[a] <= mem[a] & d`, so bits can only clear.
  - The array update is applied when the busy counter expires.
  - Next state is BUSY_PROG.
- ERASE_SETUP:
  - Next write with 0xD0 → BUSY_ERASE, on the block `a[ADDR_W-1:BLK_W]`.
  - Any other value → set bits 5 and 4, go to READ_STATUS.
- BUSY_* states:
  - Bit7 = 0 and `NF_STS` = 0.
  - All bus writes are ignored.
  - The counter reloads at entry and decrements once per clock.
  - At 0 the array update is applied: program writes the word; erase sets all 2**BLK_W words to all ones.
  - Then bit7 = 1 and the FSM goes to READ_STATUS.
- `NF_RP`=0 acts exactly like `rst`. An operation in progress is aborted with no array change.

## Timing
- Reset values: mode READ_ARRAY, status 0x80, `NF_STS`=1, counter 0, capture registers 0, `NF_D` Z.
- Read data is combinational from the registered mode: zero cycles from `NF_A`.
- Command effect: the new mode is visible on the clock after the `NF_WE` rising edge is sampled.
- Program busy lasts exactly PROG_CYCLES clocks, counted from the first clock after the confirming write is detected.
- Erase busy lasts exactly ERASE_CYCLES clocks, counted the same way.
- `NF_STS` returns to 1 on the same edge the array update becomes visible.
- If `rst` and a `NF_WE` rising edge occur in the same clock, reset wins and the write is dropped.

## Configuration
- Macro: `FLASH_MODEL_WP_EN`.
- With the macro defined: when `NF_WP`=0, a program or erase aimed at block 0 sets status bit1 plus bit4 (program) or bit5 (erase). The array is untouched and the FSM goes straight to READ_STATUS with no busy period.
- Without the macro: `NF_WP` is ignored and bit1 always reads 0.

## Structure
- Shared package `flash_pkg`:
  - Mode enum.
  - Command constants: CMD_READ_ARRAY 0xFF, CMD_READ_STATUS 0x70, CMD_CLEAR_STATUS 0x50, CMD_PROGRAM 0x40 / 0x10, CMD_ERASE 0x20, CMD_CONFIRM 0xD0.
  - Status bit indices.
- One sub-module, `flash_we_capture`: synchronises `NF_WE`, registers address/data and emits a one-clock `wr_stb`.

## Test plan
- Reset, then read addr 0x12 → 0xFF; `NF_STS`=1; status read via 0x70 → 0x80.
- Write 0x40 then 0xA5 at addr 0x12 → `NF_STS` low for 16 clocks; then status 0x80; then 0xFF command and read addr 0x12 → 0xA5.
- Program 0x5A over the 0xA5 at addr 0x12 → reads 0x00, the AND result.
- Erase with 0x20 then 0xD0 at addr 0x13 → busy 256 clocks; addrs 0x10–0x1F read 0xFF; addr 0x20 is unchanged.
- Write 0x20 then 0x33 → status 0xB0, no busy; write 0x50 → status 0x80.
- Mid-operation abort: start a program, pull `NF_RP` low on busy clock 5 → status 0x80, mode READ_ARRAY, target word unchanged.
- WP check, `NF_WP`=0, program addr 0x03:
  - With `FLASH_MODEL_WP_EN` → status 0x92, word unchanged.
  - Without the macro → the program succeeds.
